cdp_dp_mul_pipe: RTL and testbench

Multi-lane, two-stage pipelined signed multiplier for the CDP datapath, replacing the single-lane one-register multiplier unit. Each of `pLANES` lanes multiplies a signed A operand (normalised data) by a signed B operand (LUT/coefficient). The product is then right-shifted with round-half-up and optionally saturated to an output width. Full valid/ready backpressure applies at every stage, and a saturation event counter is provided for debug/perf readback.

---
 rtl/cdp_dp_mul_pipe_if.sv | 42 ++++
 rtl/cdp_dp_mul_pipe.sv | 150 +++++++++++++++
 tb/tb_cdp_dp_mul_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdp_dp_mul_pipe_if.sv
// Beat-level handshake bundle for the CDP multiplier pipe: input beat
// (operands + valid/ready) and output beat (results + flags + valid/ready).
interface cdp_dp_mul_pipe_if #(
    parameter int unsigned pLANES  = 4,
    parameter int unsigned pINA_BW = 9,
    parameter int unsigned pINB_BW = 16,
    parameter int unsigned pOUT_BW = 16
);
    logic                        mul_vld;
    logic                        mul_rdy;
    logic [pLANES*pINA_BW-1:0]   mul_ina_pd;
    logic [pLANES*pINB_BW-1:0]   mul_inb_pd;

    logic                        mul_unit_vld;
    logic                        mul_unit_rdy;
    logic [pLANES*pOUT_BW-1:0]   mul_unit_pd;
    logic [pLANES-1:0]           mul_unit_sat;

    // Upstream producer / downstream consumer side
    modport master (
        output mul_vld,
        output mul_ina_pd,
        output mul_inb_pd,
        input  mul_rdy,
        input  mul_unit_vld,
        input  mul_unit_pd,
        input  mul_unit_sat,
        output mul_unit_rdy
    );

    // Multiplier pipe side
    modport slave (
        input  mul_vld,
        input  mul_ina_pd,
        input  mul_inb_pd,
        output mul_rdy,
        output mul_unit_vld,
        output mul_unit_pd,
        output mul_unit_sat,
        input  mul_unit_rdy
    );
endinterface

// File: rtl/cdp_dp_mul_pipe.sv
// Multi-lane two-stage signed multiplier for the CDP datapath.
// S1 holds the exact per-lane product plus the config captured with the beat;
// S2 (the output register) holds the shifted, rounded and saturated result.
module cdp_dp_mul_pipe #(
    parameter int unsigned pLANES  = 4,
    parameter int unsigned pINA_BW = 9,
    parameter int unsigned pINB_BW = 16,
    parameter int unsigned pOUT_BW = 16
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    cdp_dp_mul_pipe_if.slave        mul_if,
    input  logic [4:0]              cfg_shift,
    input  logic                    cfg_sat_en,
    input  logic                    sat_cnt_clr,
    output logic [31:0]             sat_cnt
);

    localparam int unsigned W  = pINA_BW + pINB_BW;
    localparam int unsigned RW = W + 1;
    // Extended width leaves room for a rounding constant up to 2^30.
    localparam int unsigned EW = W + 33;
    localparam int unsigned CW = $clog2(pLANES + 1);

    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW - pOUT_BW + 1){1'b0}}, {(pOUT_BW - 1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN =
        {{(RW - pOUT_BW + 1){1'b1}}, {(pOUT_BW - 1){1'b0}}};
    localparam logic [pOUT_BW-1:0] OUT_MAX = {1'b0, {(pOUT_BW - 1){1'b1}}};
    localparam logic [pOUT_BW-1:0] OUT_MIN = {1'b1, {(pOUT_BW - 1){1'b0}}};

    // Stage 1 state
    logic                    s1_vld;
    logic signed [W-1:0]     s1_prod [pLANES];
    logic [4:0]              s1_shift;
    logic                    s1_sat_en;

    // Handshake
    logic                    s1_rdy;
    logic                    s2_rdy;
    logic                    s1_load;
    logic                    s2_load;

    // Combinational datapath
    logic signed [W-1:0]     prod_c [pLANES];
    logic signed [EW-1:0]    ext_c;
    logic signed [RW-1:0]    rnd_c;
    logic [pLANES*pOUT_BW-1:0] res_c;
    logic [pLANES-1:0]       sat_c;
    logic [CW-1:0]           sat_pop_c;
    logic [32:0]             cnt_sum_c;

    // Stage handshakes; mul_rdy depends only on pipe state and mul_unit_rdy
    assign s2_rdy         = ~mul_if.mul_unit_vld | mul_if.mul_unit_rdy;
    assign s1_rdy         = ~s1_vld | s2_rdy;
    assign mul_if.mul_rdy = s1_rdy;
    assign s1_load        = mul_if.mul_vld & s1_rdy;
    assign s2_load        = s1_vld & s2_rdy;

    // Exact signed per-lane products of the incoming beat
    always_comb begin
        for (int unsigned i = 0; i < pLANES; i++) begin
            prod_c[i] = W'(signed'(mul_if.mul_ina_pd[i*pINA_BW +: pINA_BW])) *
                        W'(signed'(mul_if.mul_inb_pd[i*pINB_BW +: pINB_BW]));
        end
    end

    // Stage 1 register: product plus the config that belongs to this beat
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            s1_vld    <= 1'b0;
            s1_shift  <= 5'd0;
            s1_sat_en <= 1'b0;
            for (int unsigned i = 0; i < pLANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else begin
            if (s1_load) begin
                s1_vld <= 1'b1;
            end else if (s2_rdy) begin
                s1_vld <= 1'b0;
            end
            if (s1_load) begin
                s1_prod   <= prod_c;
                s1_shift  <= cfg_shift;
                s1_sat_en <= cfg_sat_en;
            end
        end
    end

    // Round-half-up arithmetic shift, then saturate or truncate per lane
    always_comb begin
        ext_c     = '0;
        rnd_c     = '0;
        res_c     = '0;
        sat_c     = '0;
        sat_pop_c = '0;
        for (int unsigned i = 0; i < pLANES; i++) begin
            ext_c = EW'(s1_prod[i]);
            if (s1_shift != 5'd0) begin
                ext_c = ext_c + (EW'(1) << (s1_shift - 5'd1));
            end
            ext_c = ext_c >>> s1_shift;
            rnd_c = RW'(ext_c);
            if (s1_sat_en && (rnd_c > SAT_MAX)) begin
                res_c[i*pOUT_BW +: pOUT_BW] = OUT_MAX;
                sat_c[i]                    = 1'b1;
            end else if (s1_sat_en && (rnd_c < SAT_MIN)) begin
                res_c[i*pOUT_BW +: pOUT_BW] = OUT_MIN;
                sat_c[i]                    = 1'b1;
            end else begin
                res_c[i*pOUT_BW +: pOUT_BW] = rnd_c[pOUT_BW-1:0];
            end
            sat_pop_c = sat_pop_c + CW'(sat_c[i]);
        end
    end

    // Stage 2 / output register; content held while stalled
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            mul_if.mul_unit_vld <= 1'b0;
            mul_if.mul_unit_pd  <= '0;
            mul_if.mul_unit_sat <= '0;
        end else begin
            if (s2_load) begin
                mul_if.mul_unit_vld <= 1'b1;
            end else if (mul_if.mul_unit_rdy) begin
                mul_if.mul_unit_vld <= 1'b0;
            end
            if (s2_load) begin
                mul_if.mul_unit_pd  <= res_c;
                mul_if.mul_unit_sat <= sat_c;
            end
        end
    end

    assign cnt_sum_c = {1'b0, sat_cnt} + 33'(sat_pop_c);

    // Saturating event counter; clear wins over a same-cycle increment
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            sat_cnt <= 32'd0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= 32'd0;
        end else if (s2_load) begin
            sat_cnt <= cnt_sum_c[32] ? 32'hFFFF_FFFF : cnt_sum_c[31:0];
        end
    end

endmodule

// File: tb/tb_cdp_dp_mul_pipe.sv
// Directed bench for cdp_dp_mul_pipe: reset, products, rounding, saturation,
// counter clear, random backpressure against a reference model, per-beat
// config and reset with beats in flight.
module tb_cdp_dp_mul_pipe;

    localparam int unsigned LANES = 4;
    localparam int unsigned INA   = 9;
    localparam int unsigned INB   = 16;
    localparam int unsigned OUTW  = 16;

    logic        clk;
    logic        rstn;
    logic [4:0]  cfg_shift;
    logic        cfg_sat_en;
    logic        sat_cnt_clr;
    logic [31:0] sat_cnt;

    int n_assert;
    int n_fail;

    cdp_dp_mul_pipe_if #(.pLANES(LANES), .pINA_BW(INA), .pINB_BW(INB), .pOUT_BW(OUTW)) mif ();

    cdp_dp_mul_pipe #(.pLANES(LANES), .pINA_BW(INA), .pINB_BW(INB), .pOUT_BW(OUTW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .mul_if          (mif),
        .cfg_shift       (cfg_shift),
        .cfg_sat_en      (cfg_sat_en),
        .sat_cnt_clr     (sat_cnt_clr),
        .sat_cnt         (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input int a0, input int a1, input int a2, input int a3,
                             input int b0, input int b1, input int b2, input int b3);
        mif.mul_ina_pd = {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
        mif.mul_inb_pd = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    endtask

    // One isolated beat with an unstalled output; checks latency and result
    task automatic one_beat(input string tag, input logic [63:0] exp_pd,
                            input logic [3:0] exp_sat, input logic [31:0] exp_cnt);
        mif.mul_vld = 1'b1;
        tick();
        mif.mul_vld = 1'b0;
        chk({tag, "_early_vld"}, 64'(mif.mul_unit_vld), 64'(0));
        tick();
        chk({tag, "_vld"}, 64'(mif.mul_unit_vld), 64'(1));
        chk({tag, "_pd"},  64'(mif.mul_unit_pd),  exp_pd);
        chk({tag, "_sat"}, 64'(mif.mul_unit_sat), 64'(exp_sat));
        chk({tag, "_cnt"}, 64'(sat_cnt),          64'(exp_cnt));
        tick();
    endtask

    // Reference: exact product, floor((P + 2^(s-1)) / 2^s), then clip or wrap
    function automatic void model(input logic [35:0] ina, input logic [63:0] inb,
                                  input logic [4:0] s, input logic sat_en,
                                  output logic [63:0] pd, output logic [3:0] sat);
        logic signed [8:0]  a9;
        logic signed [15:0] b16;
        longint p;
        longint r;
        pd  = '0;
        sat = '0;
        for (int i = 0; i < 4; i++) begin
            a9  = ina[i*9 +: 9];
            b16 = inb[i*16 +: 16];
            p   = longint'(a9) * longint'(b16);
            if (s != 5'd0) p = p + (longint'(1) <<< (s - 5'd1));
            r = p >>> s;
            if (sat_en && r > 32767) begin
                pd[i*16 +: 16] = 16'h7FFF;
                sat[i]         = 1'b1;
            end else if (sat_en && r < -32768) begin
                pd[i*16 +: 16] = 16'h8000;
                sat[i]         = 1'b1;
            end else begin
                pd[i*16 +: 16] = r[15:0];
            end
        end
    endfunction

    logic [63:0] exp_pd_q[$];
    logic [3:0]  exp_sat_q[$];

    initial begin
        logic [63:0] m_pd;
        logic [3:0]  m_sat;
        logic [63:0] prev_pd;
        logic [3:0]  prev_sat;
        logic        prev_stall;
        logic        acc;
        logic        pop;
        int          sent;
        int          got;
        int          inflight;
        int          cyc;

        n_assert          = 0;
        n_fail            = 0;
        rstn              = 1'b0;
        cfg_shift         = 5'd0;
        cfg_sat_en        = 1'b0;
        sat_cnt_clr       = 1'b0;
        mif.mul_vld       = 1'b0;
        mif.mul_unit_rdy  = 1'b1;
        mif.mul_ina_pd    = '0;
        mif.mul_inb_pd    = '0;

        // Reset / idle
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        chk("rst_vld", 64'(mif.mul_unit_vld), 64'(0));
        chk("rst_pd",  64'(mif.mul_unit_pd),  64'(0));
        chk("rst_sat", 64'(mif.mul_unit_sat), 64'(0));
        chk("rst_cnt", 64'(sat_cnt),          64'(0));
        chk("rst_rdy", 64'(mif.mul_rdy),      64'(1));

        // Basic products, truncate
        set_lanes(-256, 255, 1, 0, -32768, 32767, -1, 5);
        one_beat("basic", 64'h0000_FFFF_7F01_0000, 4'h0, 32'd0);

        // Rounding, ties toward +inf
        cfg_shift = 5'd1;
        set_lanes(3, -3, 0, 0, 1, 1, 0, 0);
        one_beat("rnd_s1", 64'h0000_0000_FFFF_0002, 4'h0, 32'd0);
        cfg_shift = 5'd4;
        set_lanes(24, -24, -8, 8, 1, 1, 1, 1);
        one_beat("rnd_s4", 64'h0001_0000_FFFF_0002, 4'h0, 32'd0);
        cfg_shift = 5'd24;
        set_lanes(-256, 255, -256, -1, -32768, -32768, 32767, 1);
        one_beat("rnd_s24", 64'h0000_0000_0000_0001, 4'h0, 32'd0);
        cfg_shift = 5'd31;
        set_lanes(-256, -1, 255, 0, -32768, 1, 32767, 0);
        one_beat("rnd_s31", 64'h0000_0000_0000_0000, 4'h0, 32'd0);

        // Saturation: three back-to-back clipped beats
        cfg_shift  = 5'd0;
        cfg_sat_en = 1'b1;
        set_lanes(255, 255, 255, 255, 32767, 32767, 32767, 32767);
        mif.mul_vld = 1'b1;
        tick();
        chk("sat_b0_early", 64'(mif.mul_unit_vld), 64'(0));
        tick();
        chk("sat_b1_pd",  64'(mif.mul_unit_pd),  64'h7FFF_7FFF_7FFF_7FFF);
        chk("sat_b1_sat", 64'(mif.mul_unit_sat), 64'hF);
        chk("sat_b1_cnt", 64'(sat_cnt),          64'(4));
        tick();
        mif.mul_vld = 1'b0;
        chk("sat_b2_cnt", 64'(sat_cnt),          64'(8));
        tick();
        chk("sat_b3_vld", 64'(mif.mul_unit_vld), 64'(1));
        chk("sat_b3_cnt", 64'(sat_cnt),          64'(12));
        tick();

        // Fourth clipped beat reaches the output on the clear cycle
        mif.mul_vld = 1'b1;
        tick();
        mif.mul_vld = 1'b0;
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        chk("clr_sat", 64'(mif.mul_unit_sat), 64'hF);
        chk("clr_cnt", 64'(sat_cnt),          64'(0));
        tick();
        chk("clr_cnt_after", 64'(sat_cnt),    64'(0));

        // Clip boundaries: exact max/min pass, one beyond clips
        set_lanes(-256, 1, -1, 1, 32767, 32767, -32768, -32768);
        one_beat("sat_edge", 64'h8000_7FFF_7FFF_8000, 4'b0101, 32'd2);

        // Per-beat config: shift changes between back-to-back beats
        cfg_sat_en = 1'b0;
        cfg_shift  = 5'd0;
        set_lanes(100, 100, 100, 100, 100, 100, 100, 100);
        mif.mul_vld = 1'b1;
        tick();
        cfg_shift = 5'd8;
        tick();
        mif.mul_vld = 1'b0;
        chk("cfg_b0_pd", 64'(mif.mul_unit_pd), 64'h2710_2710_2710_2710);
        tick();
        chk("cfg_b1_vld", 64'(mif.mul_unit_vld), 64'(1));
        chk("cfg_b1_pd",  64'(mif.mul_unit_pd),  64'h0027_0027_0027_0027);
        tick();
        chk("cfg_idle_vld", 64'(mif.mul_unit_vld), 64'(0));

        // Random backpressure with model scoreboard
        sent       = 0;
        got        = 0;
        inflight   = 0;
        prev_stall = 1'b0;
        prev_pd    = '0;
        prev_sat   = '0;
        cyc        = 0;
        while (got < 10 && cyc < 400) begin
            mif.mul_unit_rdy = 1'($urandom_range(0, 1));
            if (sent < 10 && $urandom_range(0, 3) != 0) begin
                mif.mul_vld    = 1'b1;
                mif.mul_ina_pd = 36'({$urandom(), $urandom()});
                mif.mul_inb_pd = {$urandom(), $urandom()};
                cfg_shift      = 5'($urandom_range(0, 31));
                cfg_sat_en     = 1'($urandom_range(0, 1));
            end else begin
                mif.mul_vld = 1'b0;
            end
            #3;
            chk("bp_rdy", 64'(mif.mul_rdy),
                64'(!(inflight == 2 && !mif.mul_unit_rdy)));
            if (prev_stall) begin
                chk("bp_hold_vld", 64'(mif.mul_unit_vld), 64'(1));
                chk("bp_hold_pd",  64'(mif.mul_unit_pd),  prev_pd);
                chk("bp_hold_sat", 64'(mif.mul_unit_sat), 64'(prev_sat));
            end
            pop = mif.mul_unit_vld & mif.mul_unit_rdy;
            acc = mif.mul_vld & mif.mul_rdy;
            if (pop) begin
                n_assert++;
                assert (exp_pd_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL bp_extra_beat: observed an output beat expected none");
                end
                if (exp_pd_q.size() > 0) begin
                    chk("bp_pd",  64'(mif.mul_unit_pd),  exp_pd_q.pop_front());
                    chk("bp_sat", 64'(mif.mul_unit_sat), 64'(exp_sat_q.pop_front()));
                end
                got++;
                inflight--;
            end
            if (acc) begin
                model(mif.mul_ina_pd, mif.mul_inb_pd, cfg_shift, cfg_sat_en, m_pd, m_sat);
                exp_pd_q.push_back(m_pd);
                exp_sat_q.push_back(m_sat);
                sent++;
                inflight++;
            end
            prev_stall = mif.mul_unit_vld & ~mif.mul_unit_rdy;
            prev_pd    = mif.mul_unit_pd;
            prev_sat   = mif.mul_unit_sat;
            tick();
            cyc++;
        end
        mif.mul_vld      = 1'b0;
        mif.mul_unit_rdy = 1'b1;
        chk("bp_sent",  64'(sent), 64'(10));
        chk("bp_got",   64'(got),  64'(10));
        chk("bp_left",  64'(exp_pd_q.size()), 64'(0));
        tick();
        chk("bp_drained", 64'(mif.mul_unit_vld), 64'(0));

        // Reset with two beats in flight behind a stalled output
        cfg_shift        = 5'd0;
        cfg_sat_en       = 1'b1;
        mif.mul_unit_rdy = 1'b0;
        set_lanes(255, 255, 255, 255, 32767, 32767, 32767, 32767);
        mif.mul_vld = 1'b1;
        tick();
        tick();
        mif.mul_vld = 1'b0;
        chk("mid_full_vld", 64'(mif.mul_unit_vld), 64'(1));
        chk("mid_full_rdy", 64'(mif.mul_rdy),      64'(0));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_vld", 64'(mif.mul_unit_vld), 64'(0));
        chk("mid_rst_pd",  64'(mif.mul_unit_pd),  64'(0));
        chk("mid_rst_cnt", 64'(sat_cnt),          64'(0));
        chk("mid_rst_rdy", 64'(mif.mul_rdy),      64'(1));
        mif.mul_unit_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_no_beat", 64'(mif.mul_unit_vld), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
